// File: rtl/ram_seq_ctrl_pkg.sv
// Shared types and encodings for the BRAM sequencer: FSM states and request modes.
package bram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [1:0] MODE_WR_RD = 2'b00;
  localparam logic [1:0] MODE_WR    = 2'b01;
  localparam logic [1:0] MODE_RD    = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

endpackage

// File: rtl/ram_seq_ctrl_if.sv
// Request/response bundle of the RAM sequencer; the requester drives master, the sequencer is slave.
interface ram_seq_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int ERRC_W = 8
);

  logic              start;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   len;
  logic [DATA_W-1:0] seed;

  logic              busy;
  logic [ADDR_W-1:0] addr_out;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              done_w;
  logic              done_r;
  logic              err;
  logic [ERRC_W-1:0] err_cnt;

  modport master (
    output start, mode, base_addr, len, seed,
    input  busy, addr_out, data_out, data_valid, done_w, done_r, err, err_cnt
  );

  modport slave (
    input  start, mode, base_addr, len, seed,
    output busy, addr_out, data_out, data_valid, done_w, done_r, err, err_cnt
  );

endinterface

// File: rtl/ram_seq_ctrl_sp_ram.sv
// Single-port RAM with one-cycle synchronous read; written so synthesis maps it to block RAM.
module sp_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array is deliberately not reset; a reset port would stop block-RAM inference.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ram_seq_ctrl.sv
// RAM bring-up sequencer: writes an incrementing pattern over a wrapping window, reads it back
// and counts mismatches against the same pattern.
module ram_seq_ctrl
  import bram_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int ERRC_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  ram_seq_ctrl_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  state_t            state, state_nxt;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  len_q, idx;
  logic [DATA_W-1:0] seed_q, exp_q, hold_q, ram_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we, last_word, req_ok;
  logic              valid_q, done_w_q, err_q;
  logic [ERRC_W-1:0] err_cnt_q;

  assign last_word = (idx == len_q - CNT_W'(1));
  assign req_ok    = (bus.len != '0) && (bus.len <= CNT_W'(DEPTH)) && (bus.mode != MODE_RSVD);
  // Address arithmetic stays in ADDR_W bits so the window wraps around the top of the RAM.
  assign ram_addr  = base_q + idx[ADDR_W-1:0];

  sp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (seed_q + DATA_W'(idx)),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    case (state)
      IDLE:  if (bus.start && req_ok) state_nxt = (bus.mode == MODE_RD) ? READ : WRITE;
      WRITE: begin
        ram_we = 1'b1;
        if (last_word) state_nxt = (mode_q == MODE_WR_RD) ? READ : IDLE;
      end
      READ:  if (last_word) state_nxt = DRAIN;
      DRAIN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments only, so every read sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_WR_RD;
      base_q    <= '0;
      len_q     <= '0;
      seed_q    <= '0;
      idx       <= '0;
      exp_q     <= '0;
      hold_q    <= '0;
      valid_q   <= 1'b0;
      done_w_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      done_w_q <= 1'b0;
      err_q    <= 1'b0;
      valid_q  <= (state == READ);
      // Expected word travels alongside the read so it lines up with the RAM output.
      if (state == READ) exp_q <= seed_q + DATA_W'(idx);
      if (valid_q) hold_q <= ram_rdata;
      if (valid_q && (ram_rdata != exp_q) && (err_cnt_q != '1))
        err_cnt_q <= err_cnt_q + ERRC_W'(1);

      case (state)
        IDLE: if (bus.start) begin
          if (req_ok) begin
            mode_q    <= bus.mode;
            base_q    <= bus.base_addr;
            len_q     <= bus.len;
            seed_q    <= bus.seed;
            idx       <= '0;
            err_cnt_q <= '0;
          end else begin
            err_q <= 1'b1;
          end
        end
        WRITE: begin
          idx      <= last_word ? '0 : idx + CNT_W'(1);
          done_w_q <= last_word;
        end
        READ:  idx <= last_word ? '0 : idx + CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.addr_out   = ram_addr;
  assign bus.data_out   = valid_q ? ram_rdata : hold_q;
  assign bus.data_valid = valid_q;
  assign bus.done_w     = done_w_q;
  assign bus.done_r     = (state == DRAIN);
  assign bus.err        = err_q;
  assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Directed bench for ram_seq_ctrl: cycle-accurate timing, wrap, compare, rejects, reset, saturation.
module tb_ram_seq_ctrl;
  import bram_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_seq_ctrl_if #(.DATA_W(16), .ADDR_W(4), .ERRC_W(8)) bus0 ();
  ram_seq_ctrl_if #(.DATA_W(16), .ADDR_W(4), .ERRC_W(2)) bus1 ();

  ram_seq_ctrl #(.DATA_W(16), .ADDR_W(4), .ERRC_W(8)) dut     (.clk(clk), .rst(rst), .bus(bus0));
  ram_seq_ctrl #(.DATA_W(16), .ADDR_W(4), .ERRC_W(2)) dut_sat (.clk(clk), .rst(rst), .bus(bus1));

  int tests = 0;
  int fails = 0;

  // Per-operation trace, indexed by cycle offset c from the start cycle T.
  int          dw_cnt, dw_cyc, dr_cnt, dr_cyc, nvalid, busy_cnt, err_pulses;
  logic [15:0] vdata [64];
  int          vcyc  [64];
  logic [3:0]  addr_tr [64];
  logic [32:0] out_vec [64];

  task automatic run_op(input logic [1:0] m, input logic [3:0] b, input logic [4:0] l,
                        input logic [15:0] s, input int ncyc, input int poke_c, input int rst_c);
    dw_cnt = 0; dw_cyc = -1; dr_cnt = 0; dr_cyc = -1; nvalid = 0; busy_cnt = 0; err_pulses = 0;
    @(negedge clk);
    bus0.mode = m; bus0.base_addr = b; bus0.len = l; bus0.seed = s; bus0.start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      bus0.start = 1'b0;
      if (c == poke_c) begin
        bus0.start = 1'b1; bus0.mode = MODE_RD; bus0.base_addr = 4'd8;
        bus0.len = 5'd2; bus0.seed = 16'hBEEF;
      end
      if (bus0.done_w) begin dw_cnt++; dw_cyc = c; end
      if (bus0.done_r) begin dr_cnt++; dr_cyc = c; end
      if (bus0.busy) busy_cnt++;
      if (bus0.err) err_pulses++;
      if (bus0.data_valid && nvalid < 64) begin
        vdata[nvalid] = bus0.data_out; vcyc[nvalid] = c; nvalid++;
      end
      addr_tr[c] = bus0.addr_out;
      out_vec[c] = {bus0.busy, bus0.addr_out, bus0.data_out, bus0.data_valid,
                    bus0.done_w, bus0.done_r, bus0.err, bus0.err_cnt};
      if (rst_c > 0 && c == rst_c) rst = 1'b1;
      if (rst_c > 0 && c == rst_c + 1) rst = 1'b0;
    end
    bus0.start = 1'b0;
  endtask

  task automatic run_sat(input logic [1:0] m, input logic [4:0] l, input logic [15:0] s, input int ncyc);
    @(negedge clk);
    bus1.mode = m; bus1.base_addr = 4'd0; bus1.len = l; bus1.seed = s; bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (ncyc - 1) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus0.start = 1'b0; bus0.mode = 2'b00; bus0.base_addr = '0; bus0.len = '0; bus0.seed = '0;
    bus1.start = 1'b0; bus1.mode = 2'b00; bus1.base_addr = '0; bus1.len = '0; bus1.seed = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus0.busy, bus0.addr_out, bus0.data_out, bus0.data_valid, bus0.done_w, bus0.done_r,
         bus0.err, bus0.err_cnt} !== 33'd0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b addr=%0h data=%0h dv=%b dw=%b dr=%b err=%b cnt=%0d expected all 0",
               bus0.busy, bus0.addr_out, bus0.data_out, bus0.data_valid, bus0.done_w, bus0.done_r,
               bus0.err, bus0.err_cnt);
    end
    tests++;
    if (bus1.err_cnt !== 2'd0 || bus1.busy !== 1'b0) begin
      fails++; $display("FAIL reset_sat_outputs: got cnt=%0d busy=%b expected 0 0", bus1.err_cnt, bus1.busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_defaults();
    run_op(MODE_WR_RD, 4'd0, 5'd16, 16'h0100, 34, 0, 0);
    tests++;
    if (dw_cnt !== 1 || dw_cyc !== 17) begin
      fails++; $display("FAIL defaults_done_w: got count=%0d cycle=%0d expected 1 at 17", dw_cnt, dw_cyc);
    end
    for (int k = 0; k < 16; k++) begin
      tests++;
      if (addr_tr[k+1] !== 4'(k)) begin
        fails++; $display("FAIL defaults_write_addr[%0d]: got %0d expected %0d", k, addr_tr[k+1], k);
      end
    end
    tests++;
    if (nvalid !== 16) begin
      fails++; $display("FAIL defaults_valid_count: got %0d expected 16", nvalid);
    end
    for (int k = 0; k < 16; k++) begin
      tests++;
      if (vdata[k] !== 16'h0100 + 16'(k) || vcyc[k] !== 18 + k) begin
        fails++;
        $display("FAIL defaults_read[%0d]: got %0h at %0d expected %0h at %0d",
                 k, vdata[k], vcyc[k], 16'h0100 + 16'(k), 18 + k);
      end
    end
    tests++;
    if (dr_cnt !== 1 || dr_cyc !== 33) begin
      fails++; $display("FAIL defaults_done_r: got count=%0d cycle=%0d expected 1 at 33", dr_cnt, dr_cyc);
    end
    tests++;
    if (busy_cnt !== 33 || out_vec[34][32] !== 1'b0) begin
      fails++; $display("FAIL defaults_busy: got %0d cycles expected 33", busy_cnt);
    end
    tests++;
    if (bus0.err_cnt !== 8'd0) begin
      fails++; $display("FAIL defaults_err_cnt: got %0d expected 0", bus0.err_cnt);
    end
  endtask

  task automatic test_read_only();
    run_op(MODE_RD, 4'd0, 5'd4, 16'h0100, 6, 0, 0);
    tests++;
    if (nvalid !== 4 || vcyc[0] !== 2 || dr_cyc !== 5 || dw_cnt !== 0) begin
      fails++;
      $display("FAIL rdonly_timing: got n=%0d first=%0d done_r=%0d done_w=%0d expected 4 2 5 0",
               nvalid, vcyc[0], dr_cyc, dw_cnt);
    end
    tests++;
    if (vdata[3] !== 16'h0103) begin
      fails++; $display("FAIL rdonly_last_word: got %0h expected 0103", vdata[3]);
    end
    tests++;
    if (bus0.err_cnt !== 8'd0) begin
      fails++; $display("FAIL rdonly_match_err_cnt: got %0d expected 0", bus0.err_cnt);
    end
    run_op(MODE_RD, 4'd0, 5'd4, 16'h0200, 6, 0, 0);
    tests++;
    if (bus0.err_cnt !== 8'd4) begin
      fails++; $display("FAIL rdonly_mismatch_err_cnt: got %0d expected 4", bus0.err_cnt);
    end
    tests++;
    if (vdata[0] !== 16'h0100) begin
      fails++; $display("FAIL rdonly_mismatch_data: got %0h expected 0100", vdata[0]);
    end
  endtask

  task automatic test_rejects();
    logic [1:0] rm [3];
    logic [4:0] rl [3];
    rm[0] = MODE_WR_RD; rl[0] = 5'd0;
    rm[1] = MODE_WR_RD; rl[1] = 5'd17;
    rm[2] = MODE_RSVD;  rl[2] = 5'd4;
    for (int k = 0; k < 3; k++) begin
      run_op(rm[k], 4'd0, rl[k], 16'h1234, 4, 0, 0);
      tests++;
      if (err_pulses !== 1 || out_vec[1][4+8-4] !== 1'b1) begin
        fails++; $display("FAIL reject_err_pulse[%0d]: got %0d pulses expected 1 at cycle 1", k, err_pulses);
      end
      tests++;
      if (busy_cnt !== 0 || dw_cnt !== 0 || dr_cnt !== 0 || nvalid !== 0) begin
        fails++;
        $display("FAIL reject_quiet[%0d]: got busy=%0d dw=%0d dr=%0d valid=%0d expected all 0",
                 k, busy_cnt, dw_cnt, dr_cnt, nvalid);
      end
      tests++;
      if (bus0.err_cnt !== 8'd4) begin
        fails++; $display("FAIL reject_keeps_err_cnt[%0d]: got %0d expected 4", k, bus0.err_cnt);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0]  ea [4];
    logic [15:0] ed [4];
    ea[0] = 4'd14; ea[1] = 4'd15; ea[2] = 4'd0; ea[3] = 4'd1;
    ed[0] = 16'hFFFE; ed[1] = 16'hFFFF; ed[2] = 16'h0000; ed[3] = 16'h0001;
    run_op(MODE_WR_RD, 4'd14, 5'd4, 16'hFFFE, 10, 0, 0);
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (addr_tr[k+1] !== ea[k] || addr_tr[k+5] !== ea[k]) begin
        fails++;
        $display("FAIL wrap_addr[%0d]: got wr=%0d rd=%0d expected %0d", k, addr_tr[k+1], addr_tr[k+5], ea[k]);
      end
      tests++;
      if (vdata[k] !== ed[k]) begin
        fails++; $display("FAIL wrap_data[%0d]: got %0h expected %0h", k, vdata[k], ed[k]);
      end
    end
    tests++;
    if (dw_cyc !== 5 || dr_cyc !== 9 || bus0.err_cnt !== 8'd0) begin
      fails++;
      $display("FAIL wrap_done_cnt: got dw=%0d dr=%0d cnt=%0d expected 5 9 0", dw_cyc, dr_cyc, bus0.err_cnt);
    end
  endtask

  task automatic test_start_mid_write();
    run_op(MODE_WR, 4'd4, 5'd6, 16'h3000, 8, 3, 0);
    tests++;
    if (dw_cnt !== 1 || dw_cyc !== 7 || busy_cnt !== 6) begin
      fails++; $display("FAIL midstart_write: got dw=%0d@%0d busy=%0d expected 1@7 busy=6", dw_cnt, dw_cyc, busy_cnt);
    end
    tests++;
    if (nvalid !== 0 || dr_cnt !== 0 || err_pulses !== 0) begin
      fails++; $display("FAIL midstart_ignored: got valid=%0d dr=%0d err=%0d expected 0 0 0", nvalid, dr_cnt, err_pulses);
    end
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (addr_tr[k+1] !== 4'(4 + k)) begin
        fails++; $display("FAIL midstart_addr[%0d]: got %0d expected %0d", k, addr_tr[k+1], 4 + k);
      end
    end
    run_op(MODE_RD, 4'd4, 5'd6, 16'h3000, 8, 0, 0);
    tests++;
    if (nvalid !== 6 || vdata[5] !== 16'h3005 || bus0.err_cnt !== 8'd0) begin
      fails++;
      $display("FAIL midstart_readback: got n=%0d last=%0h cnt=%0d expected 6 3005 0", nvalid, vdata[5], bus0.err_cnt);
    end
  endtask

  task automatic test_reset_mid_op();
    run_op(MODE_WR, 4'd0, 5'd16, 16'h5000, 8, 0, 5);
    tests++;
    if (out_vec[5][32] !== 1'b1 || out_vec[6] !== 33'd0) begin
      fails++; $display("FAIL midreset_outputs: got %0h expected 0 (busy before=%b)", out_vec[6], out_vec[5][32]);
    end
    tests++;
    if (busy_cnt !== 5 || dw_cnt !== 0) begin
      fails++; $display("FAIL midreset_idle: got busy=%0d dw=%0d expected 5 0", busy_cnt, dw_cnt);
    end
    run_op(MODE_WR_RD, 4'd0, 5'd4, 16'h6000, 10, 0, 0);
    tests++;
    if (dw_cyc !== 5 || dr_cyc !== 9 || nvalid !== 4 || vdata[3] !== 16'h6003 || bus0.err_cnt !== 8'd0) begin
      fails++;
      $display("FAIL midreset_fresh_run: got dw=%0d dr=%0d n=%0d last=%0h cnt=%0d expected 5 9 4 6003 0",
               dw_cyc, dr_cyc, nvalid, vdata[3], bus0.err_cnt);
    end
  endtask

  task automatic test_saturation();
    run_sat(MODE_WR, 5'd8, 16'h0000, 10);
    run_sat(MODE_RD, 5'd8, 16'h0000, 10);
    tests++;
    if (bus1.err_cnt !== 2'd0) begin
      fails++; $display("FAIL sat_match: got %0d expected 0", bus1.err_cnt);
    end
    run_sat(MODE_RD, 5'd8, 16'h8000, 10);
    tests++;
    if (bus1.err_cnt !== 2'd3) begin
      fails++; $display("FAIL sat_limit: got %0d expected 3", bus1.err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_read_only();
    test_rejects();
    test_wrap();
    test_start_mid_write();
    test_reset_mid_op();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_seq_ctrl.md
# ram_seq_ctrl

Parametrised single-port block-RAM sequencer, the generalised successor to the fixed 16-bit write-then-read controller. On a start pulse it writes an incrementing pattern into an internal single-port RAM, reads a window back, or does both, over a programmable base address and length, with address wrap-around. It checks read data against the expected pattern and counts mismatches. It serves as the RAM bring-up and self-test engine in the BRAM subsystem.

## Interface
- DATA_W, 16: RAM word width.
- ADDR_W, 4: address width; DEPTH = 2**ADDR_W.
- ERRC_W, 8: mismatch counter width.

- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  2  00 write-then-read, 01 write-only, 10 read-only, 11 reserved (rejected).
- base_addr  in  ADDR_W  first address.
- len  in  ADDR_W+1  word count; legal 1..DEPTH.
- seed  in  DATA_W  pattern origin; word i = seed + i mod 2**DATA_W.
- busy  out  1  state != IDLE.
- addr_out  out  ADDR_W  address currently driven to RAM.
- data_out  out  DATA_W  read data.
- data_valid  out  1  data_out holds a read word.
- done_w  out  1  one-cycle pulse: write phase complete.
- done_r  out  1  one-cycle pulse: last read word valid.
- err  out  1  one-cycle pulse: request rejected.
- err_cnt  out  ERRC_W  read mismatches, saturating.

## Operation
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: start=1 latches mode, base_addr, len and seed, clears err_cnt, and zeroes the index i.
  - mode 00/01 -> WRITE.
  - mode 10 -> READ.
  - len=0, len>DEPTH or mode 11 -> err pulse next cycle; stay IDLE; err_cnt is not cleared.
- WRITE: each cycle we=1, addr = base+i (mod DEPTH), wdata = seed+i, i++.
  - After word len-1: i clears and done_w pulses the next cycle. Next state is READ (mode 00) or IDLE (mode 01).
- READ: each cycle issues addr = base+i, i++. After word len-1 -> DRAIN.
- RAM read latency is 1. data_valid and data_out appear the cycle after issue.
- Each valid word is compared with seed+k. A mismatch increments err_cnt, which saturates at all-ones.
- DRAIN: presents the last word with done_r=1, then -> IDLE.
- start while busy: ignored; no queueing.
- Address wrap: base+i computed in ADDR_W bits, so it wraps silently.
- RAM contents are not reset; they persist across rst and across operations.

## Timing
- Start accepted at cycle T.
- Mode 00, length L:
  - Writes occur on T+1..T+L; done_w pulses at T+L+1.
  - Read issues occur on T+L+1..T+2L; data_valid is high T+L+2..T+2L+1.
  - done_r pulses at T+2L+1, coincident with the last data_valid.
  - busy is high T+1..T+2L+1. A new start is accepted from T+2L+2.
- Mode 01: writes on T+1..T+L. done_w at T+L+1, in IDLE, busy low. A new start is accepted at T+L+1.
- Mode 10: issues on T+1..T+L. data_valid on T+2..T+L+1, done_r at T+L+1.
- done_w and done_r never coincide within one operation.
- Reset values, all outputs: busy 0, addr_out 0, data_out 0, data_valid 0, done_w 0, done_r 0, err 0, err_cnt 0. State is IDLE.
- rst mid-operation: the next cycle returns to IDLE with all outputs at reset values. A partially written window keeps whatever was written.
- data_out holds its last value while data_valid=0.

## Structure
- Package bram_pkg holds:
  - state enum (IDLE, WRITE, READ, DRAIN);
  - mode encodings MODE_WR_RD, MODE_WR, MODE_RD;
  - mode-11 reserved constant.
- Sub-module sp_ram: parameters DATA_W and ADDR_W; ports clk, we, addr, wdata, rdata; synchronous read of 1 cycle; no reset on the array. It infers block RAM.
- The controller holds the FSM, index counter, latched request, compare logic and saturating counter.

## Test plan
- Defaults. rst, then start mode 00, base 0, len 16, seed 0x0100:
  - done_w at T+17;
  - data_out 0x0100..0x010F on T+18..T+33;
  - done_r at T+33; err_cnt 0.
- Wrap. mode 00, base 14, len 4, seed 0xFFFE -> addr_out 14,15,0,1 and data 0xFFFE,0xFFFF,0x0000,0x0001; err_cnt 0.
- Read-only check, after the first scenario:
  - mode 10, base 0, len 4, seed 0x0100 -> err_cnt 0;
  - repeat with seed 0x0200 -> err_cnt 4.
- Rejects:
  - len 0, len 17 and mode 11 each give one err pulse, with busy, done_w and done_r staying 0;
  - a start pulse mid-WRITE is ignored, and the original operation completes unchanged.
- Reset: rst asserted at T+5 of a len-16 write -> all outputs 0 at T+6. A fresh start then runs to correct completion.
- Saturation: ERRC_W=2 with 8 mismatching reads -> err_cnt stops at 3.
